// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter.
// It runs one double-dabble (shift-add-3) iteration per clock.
// The input and output sides each use a valid/ready handshake.
// An overflow flag marks results that did not fit in DIGITS digits.
module bcd_convert_seq #(
    parameter int unsigned BIN_WIDTH = 16,
    parameter int unsigned DIGITS    = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_WIDTH-1:0] binary,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*DIGITS-1:0]  bcd,
    output logic                 overflow
);

    localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e               state_q;
    logic [BIN_WIDTH-1:0] shift_q;
    logic [BcdW-1:0]      acc_q;
    logic                 sticky_q;
    logic [CntW-1:0]      cnt_q;
    logic [BcdW-1:0]      bcd_q;
    logic                 ovf_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [BcdW-1:0]      acc_adj;
    logic [BcdW-1:0]      acc_next;
    logic                 carry_out;

    // One iteration: add 3 to each digit >= 5 (on the old values), then shift the binary MSB in.
    always_comb begin
        acc_adj = acc_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
        carry_out = acc_adj[BcdW-1];
        acc_next  = {acc_adj[BcdW-2:0], shift_q[BIN_WIDTH-1]};
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q    <= StShift;
                        shift_q    <= binary;
                        acc_q      <= '0;
                        sticky_q   <= 1'b0;
                        cnt_q      <= CntW'(BIN_WIDTH);
                        in_ready_q <= 1'b0;
                    end
                end
                StShift: begin
                    acc_q    <= acc_next;
                    shift_q  <= shift_q << 1;
                    sticky_q <= sticky_q | carry_out;
                    cnt_q    <= cnt_q - CntW'(1);
                    // The last iteration publishes the result straight from the next-state value.
                    if (cnt_q == CntW'(1)) begin
                        state_q     <= StDone;
                        bcd_q       <= acc_next;
                        ovf_q       <= sticky_q | carry_out;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign overflow  = ovf_q;

endmodule
